// File: rtl/aip_dispatch_pkg.sv
// Shared constants for the AIP port dispatcher: local register map, STATUS bit layout, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aip_dispatch_pkg;

  // Local registers. Every address below ADDR_STATUS is forwarded to the selected port.
  localparam logic [4:0] ADDR_STATUS  = 5'h1C;
  localparam logic [4:0] ADDR_MASK    = 5'h1D;
  localparam logic [4:0] ADDR_PENDING = 5'h1E;
  localparam logic [4:0] ADDR_SELECT  = 5'h1F;

  // STATUS read layout.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_SEL_LSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } disp_state_e;

  // Width of the SELECT register (never below one bit).
  function automatic int sel_width(input int n_ports);
    return (n_ports <= 2) ? 1 : $clog2(n_ports);
  endfunction

endpackage

// File: rtl/aip_int_capture.sv
// Per-port interrupt capture: rising-edge detect, PENDING (W1C, set wins), MASK, registered aggregate request.
// Latency: PENDING sets on the edge that sees the rise; o_int_req follows one cycle later.
// Backpressure: none; interrupts are captured every cycle regardless of the MCU enable.
// Ports: i_int raw port interrupts, i_set forced PENDING sets, i_clr_* W1C request, i_mask_* MASK write,
//        o_rise combinational rise vector, o_pending/o_mask register views, o_int_req aggregate interrupt.
module aip_int_capture #(
  parameter int N_PORTS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_a,
  input  logic [N_PORTS-1:0] i_int,
  input  logic [N_PORTS-1:0] i_set,
  input  logic               i_clr_vld,
  input  logic [N_PORTS-1:0] i_clr_dat,
  input  logic               i_mask_vld,
  input  logic [N_PORTS-1:0] i_mask_dat,
  output logic [N_PORTS-1:0] o_rise,
  output logic [N_PORTS-1:0] o_pending,
  output logic [N_PORTS-1:0] o_mask,
  output logic               o_int_req
);

  logic [N_PORTS-1:0] int_q;
  logic [N_PORTS-1:0] pend_q, pend_d;
  logic [N_PORTS-1:0] mask_q, mask_d;
  logic               int_req_q, int_req_d;

  assign o_rise = i_int & ~int_q;

  always_comb begin
    pend_d = pend_q;
    if (i_clr_vld) pend_d = pend_d & ~i_clr_dat;
    // New edges are applied after the clear so a same-cycle set is never lost.
    pend_d    = pend_d | o_rise | i_set;
    mask_d    = i_mask_vld ? i_mask_dat : mask_q;
    int_req_d = |(pend_q & mask_q);
  end

  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      int_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '1;
      int_req_q <= 1'b0;
    end else begin
      int_q     <= i_int;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      int_req_q <= int_req_d;
    end
  end

  assign o_pending = pend_q;
  assign o_mask    = mask_q;
  assign o_int_req = int_req_q;

endmodule

// File: rtl/aip_port_dispatcher.sv
// MCU-to-N-port AIP dispatcher: forwards config 0x00-0x1B to the selected port, runs start/busy tracking, aggregates interrupts.
// Latency: forwarded strobes 1 cycle; forwarded read data 2 cycles; local read data 1 cycle; start pulse 1 cycle.
// Backpressure: none; i_en_s low drops MCU accesses and freezes state except interrupt capture and busy completion.
// Ports: MCU side i_conf_dbus/i_read/i_write/i_start/i_data_in/o_data_out/o_int_req; port side flattened
//        o_dataInAIP_IP/o_configAIP_IP (slice k = port k), per-port strobes, i_dataOutAIP_IP, i_int_IP.
// Build option: define AIP_DISPATCH_TIMEOUT_EN to include the BUSY watchdog (TIMEOUT_CYCLES clocks).
module aip_port_dispatcher
  import aip_dispatch_pkg::*;
#(
  parameter int DATA_WORD      = 32,
  parameter int N_PORTS        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         i_clk,
  input  logic                         i_rst_a,
  input  logic                         i_en_s,
  input  logic [4:0]                   i_conf_dbus,
  input  logic                         i_read,
  input  logic                         i_write,
  input  logic                         i_start,
  input  logic [DATA_WORD-1:0]         i_data_in,
  output logic [DATA_WORD-1:0]         o_data_out,
  output logic                         o_int_req,
  output logic [N_PORTS*DATA_WORD-1:0] o_dataInAIP_IP,
  output logic [N_PORTS*5-1:0]         o_configAIP_IP,
  output logic [N_PORTS-1:0]           o_readAIP_IP,
  output logic [N_PORTS-1:0]           o_writeAIP_IP,
  output logic [N_PORTS-1:0]           o_start_IP,
  input  logic [N_PORTS*DATA_WORD-1:0] i_dataOutAIP_IP,
  input  logic [N_PORTS-1:0]           i_int_IP
);

  localparam int SEL_W = sel_width(N_PORTS);

  if (DATA_WORD < 16 || N_PORTS < 2 || N_PORTS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("aip_port_dispatcher: illegal parameter set");
  end

  // MCU access decode; read+write together is a write.
  logic acc_rd, acc_wr, start_acc, is_local, fwd_acc;
  logic wr_status, wr_mask, wr_pending, wr_select;
  assign acc_wr     = i_en_s & i_write;
  assign acc_rd     = i_en_s & i_read & ~i_write;
  assign start_acc  = i_en_s & i_start;
  assign is_local   = (i_conf_dbus >= ADDR_STATUS);
  assign fwd_acc    = (acc_rd | acc_wr) & ~is_local;
  assign wr_status  = acc_wr & (i_conf_dbus == ADDR_STATUS);
  assign wr_mask    = acc_wr & (i_conf_dbus == ADDR_MASK);
  assign wr_pending = acc_wr & (i_conf_dbus == ADDR_PENDING);
  assign wr_select  = acc_wr & (i_conf_dbus == ADDR_SELECT);

  disp_state_e          state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d, busy_port_q, busy_port_d;
  logic                 start_q, start_d, overrun_q, overrun_d;
  logic                 overrun_set, tmo_fire, tmo_hit, tmo_flag, done;
  logic [N_PORTS-1:0]   rise, pending, mask, tmo_set;
  logic                 fwd_act_q, fwd_rd_q, fwd_wr_q;
  logic [SEL_W-1:0]     fwd_port_q;
  logic [4:0]           fwd_cfg_q;
  logic [DATA_WORD-1:0] fwd_dat_q, rdata_q, rdata_d, loc_rdata, port_rdata;

  assign done = rise[busy_port_q];

  // Start/busy FSM.
  always_comb begin
    state_d     = state_q;
    busy_port_d = busy_port_q;
    start_d     = 1'b0;
    overrun_set = 1'b0;
    tmo_fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d     = ST_BUSY;
          busy_port_d = sel_q;
          start_d     = 1'b1;
        end
      end
      ST_BUSY: begin
        overrun_set = start_acc;
        if (done) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          tmo_fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AIP_DISPATCH_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d;

  // Fires on the BUSY cycle whose completion makes TIMEOUT_CYCLES elapsed BUSY cycles.
  assign tmo_hit = i_en_s && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) tmo_cnt_d = '0;
    else if (i_en_s)        tmo_cnt_d = tmo_cnt_q + 32'd1;
    tmo_flag_d = tmo_flag_q;
    if (wr_status && i_data_in[STAT_TIMEOUT]) tmo_flag_d = 1'b0;
    if (tmo_fire) tmo_flag_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  // Local register next-state, read mux and port read-data mux.
  always_comb begin
    sel_d = sel_q;
    if (wr_select && (i_data_in < DATA_WORD'(N_PORTS))) sel_d = i_data_in[SEL_W-1:0];

    overrun_d = overrun_q;
    if (wr_status && i_data_in[STAT_OVERRUN]) overrun_d = 1'b0;
    if (overrun_set) overrun_d = 1'b1;

    loc_rdata = '0;
    case (i_conf_dbus)
      ADDR_STATUS: begin
        loc_rdata[STAT_BUSY]                = (state_q == ST_BUSY);
        loc_rdata[STAT_OVERRUN]             = overrun_q;
        loc_rdata[STAT_TIMEOUT]             = tmo_flag;
        loc_rdata[STAT_SEL_LSB +: SEL_W]    = sel_q;
      end
      ADDR_MASK:    loc_rdata[N_PORTS-1:0] = mask;
      ADDR_PENDING: loc_rdata[N_PORTS-1:0] = pending;
      ADDR_SELECT:  loc_rdata[SEL_W-1:0]   = sel_q;
      default:      loc_rdata = '0;
    endcase

    port_rdata = '0;
    tmo_set    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (fwd_port_q == SEL_W'(k)) port_rdata = i_dataOutAIP_IP[k*DATA_WORD +: DATA_WORD];
      if (tmo_fire && busy_port_q == SEL_W'(k)) tmo_set[k] = 1'b1;
    end

    // A local read issued on the same edge a forwarded read completes is the newer one.
    rdata_d = rdata_q;
    if (fwd_rd_q) rdata_d = port_rdata;
    if (acc_rd && is_local) rdata_d = loc_rdata;
  end

  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      busy_port_q <= '0;
      start_q     <= 1'b0;
      overrun_q   <= 1'b0;
      rdata_q     <= '0;
      fwd_act_q   <= 1'b0;
      fwd_rd_q    <= 1'b0;
      fwd_wr_q    <= 1'b0;
      fwd_port_q  <= '0;
      fwd_cfg_q   <= '0;
      fwd_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      busy_port_q <= busy_port_d;
      start_q     <= start_d;
      overrun_q   <= overrun_d;
      rdata_q     <= rdata_d;
      fwd_act_q   <= fwd_acc;
      fwd_rd_q    <= fwd_acc & acc_rd;
      fwd_wr_q    <= fwd_acc & acc_wr;
      if (fwd_acc) begin
        fwd_port_q <= sel_q;
        fwd_cfg_q  <= i_conf_dbus;
        fwd_dat_q  <= i_data_in;
      end
    end
  end

  // Port-side fan-out: only the port latched with the access sees it, everything else stays 0.
  always_comb begin
    o_dataInAIP_IP = '0;
    o_configAIP_IP = '0;
    o_readAIP_IP   = '0;
    o_writeAIP_IP  = '0;
    o_start_IP     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (fwd_act_q && fwd_port_q == SEL_W'(k)) begin
        o_dataInAIP_IP[k*DATA_WORD +: DATA_WORD] = fwd_dat_q;
        o_configAIP_IP[k*5 +: 5]                 = fwd_cfg_q;
        o_readAIP_IP[k]                          = fwd_rd_q;
        o_writeAIP_IP[k]                         = fwd_wr_q;
      end
      if (start_q && busy_port_q == SEL_W'(k)) o_start_IP[k] = 1'b1;
    end
  end

  assign o_data_out = rdata_q;

  aip_int_capture #(
    .N_PORTS (N_PORTS)
  ) u_int_capture (
    .i_clk      (i_clk),
    .i_rst_a    (i_rst_a),
    .i_int      (i_int_IP),
    .i_set      (tmo_set),
    .i_clr_vld  (wr_pending),
    .i_clr_dat  (i_data_in[N_PORTS-1:0]),
    .i_mask_vld (wr_mask),
    .i_mask_dat (i_data_in[N_PORTS-1:0]),
    .o_rise     (rise),
    .o_pending  (pending),
    .o_mask     (mask),
    .o_int_req  (o_int_req)
  );

endmodule

// File: tb/tb_aip_port_dispatcher.sv
// Self-checking bench for aip_port_dispatcher (N_PORTS=4, DATA_WORD=32).
// Register-map table, directed multi-cycle sequences, then randomized traffic against a behavioural model.
// Honours AIP_DISPATCH_TIMEOUT_EN (watchdog of 16 cycles when defined).
`timescale 1ns/1ps
module tb_aip_port_dispatcher;

  localparam int DW = 32;
  localparam int NP = 4;
`ifdef AIP_DISPATCH_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif

  localparam logic [4:0] A_STAT = 5'h1C;
  localparam logic [4:0] A_MASK = 5'h1D;
  localparam logic [4:0] A_PEND = 5'h1E;
  localparam logic [4:0] A_SEL  = 5'h1F;

  logic             i_clk = 1'b0;
  logic             i_rst_a, i_en_s, i_read, i_write, i_start;
  logic [4:0]       i_conf_dbus;
  logic [DW-1:0]    i_data_in, o_data_out;
  logic             o_int_req;
  logic [NP*DW-1:0] o_dataInAIP_IP, i_dataOutAIP_IP;
  logic [NP*5-1:0]  o_configAIP_IP;
  logic [NP-1:0]    o_readAIP_IP, o_writeAIP_IP, o_start_IP, i_int_IP;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  aip_port_dispatcher #(
    .DATA_WORD      (DW),
    .N_PORTS        (NP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_a         (i_rst_a),
    .i_en_s          (i_en_s),
    .i_conf_dbus     (i_conf_dbus),
    .i_read          (i_read),
    .i_write         (i_write),
    .i_start         (i_start),
    .i_data_in       (i_data_in),
    .o_data_out      (o_data_out),
    .o_int_req       (o_int_req),
    .o_dataInAIP_IP  (o_dataInAIP_IP),
    .o_configAIP_IP  (o_configAIP_IP),
    .o_readAIP_IP    (o_readAIP_IP),
    .o_writeAIP_IP   (o_writeAIP_IP),
    .o_start_IP      (o_start_IP),
    .i_dataOutAIP_IP (i_dataOutAIP_IP),
    .i_int_IP        (i_int_IP)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_read = 1'b0; i_write = 1'b0; i_start = 1'b0; i_conf_dbus = '0; i_data_in = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    i_conf_dbus = a; i_data_in = d; i_write = 1'b1;
    tick();
    idle_in();
  endtask

  // Local registers only: data is valid right after the capturing edge.
  task automatic do_read(input logic [4:0] a, output logic [31:0] q);
    i_conf_dbus = a; i_read = 1'b1;
    tick();
    idle_in();
    q = o_data_out;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] q;
    do_read(a, q);
    check(name, q, exp);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic apply_reset();
    idle_in();
    i_en_s = 1'b1; i_int_IP = '0;
    i_rst_a = 1'b1;
    repeat (2) tick();
    i_rst_a = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input bit w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0]  ecfg;
    logic [127:0] edat;
    // Behavioural model state for the random phase.
    logic [1:0]   m_sel, m_bport;
    logic [3:0]   m_mask, m_pend, m_intprev, cur_int;
    bit           m_busy, m_ovr, m_tmo;
    int           m_age;

    i_dataOutAIP_IP = {32'hDDDD_0003, 32'hCCCC_0002, 32'h1234_5678, 32'hAAAA_0000};
    apply_reset();
    check("rst_int_req", o_int_req, 1'b0);
    check("rst_start",   o_start_IP, 4'h0);
    check("rst_dout",    o_data_out, 32'h0);

    // ---- register map table ----
    tbl[0]  = mk(0, A_STAT, 0, 32'h0);
    tbl[1]  = mk(0, A_MASK, 0, 32'hF);
    tbl[2]  = mk(0, A_PEND, 0, 32'h0);
    tbl[3]  = mk(0, A_SEL,  0, 32'h0);
    tbl[4]  = mk(1, A_SEL,  2, 0);
    tbl[5]  = mk(0, A_SEL,  0, 32'h2);
    tbl[6]  = mk(1, A_SEL,  7, 0);
    tbl[7]  = mk(0, A_SEL,  0, 32'h2);
    tbl[8]  = mk(1, A_SEL,  4, 0);
    tbl[9]  = mk(0, A_STAT, 0, 32'h200);
    tbl[10] = mk(1, A_MASK, 5, 0);
    tbl[11] = mk(0, A_MASK, 0, 32'h5);
    tbl[12] = mk(1, A_MASK, 32'hF, 0);
    tbl[13] = mk(1, A_SEL,  3, 0);
    tbl[14] = mk(0, A_SEL,  0, 32'h3);
    tbl[15] = mk(1, A_SEL,  0, 0);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data);
      else read_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // ---- forwarded write to port 2 ----
    do_write(A_SEL, 2);
    i_conf_dbus = 5'h03; i_data_in = 32'hA5A5; i_write = 1'b1;
    tick();
    idle_in();
    ecfg = '0; ecfg[10 +: 5] = 5'h03;
    edat = '0; edat[64 +: 32] = 32'hA5A5;
    check("fwd_wr_strobe", o_writeAIP_IP, 4'b0100);
    check("fwd_rd_strobe", o_readAIP_IP, 4'b0000);
    check("fwd_cfg",       o_configAIP_IP, ecfg);
    check("fwd_dat",       o_dataInAIP_IP, edat);
    tick();
    check("fwd_wr_single", o_writeAIP_IP, 4'b0000);
    check("fwd_cfg_clear", o_configAIP_IP, 20'h0);

    // ---- enable low blocks accesses ----
    i_en_s = 1'b0;
    i_conf_dbus = 5'h03; i_write = 1'b1;
    tick();
    idle_in();
    check("en_low_fwd", o_writeAIP_IP, 4'b0000);
    do_write(A_SEL, 1);
    i_en_s = 1'b1;
    read_chk("en_low_sel", A_SEL, 32'h2);

    // ---- read+write together is a write ----
    i_conf_dbus = 5'h05; i_data_in = 32'h1; i_read = 1'b1; i_write = 1'b1;
    tick();
    idle_in();
    check("rw_is_write", o_writeAIP_IP, 4'b0100);
    check("rw_no_read",  o_readAIP_IP, 4'b0000);

    // ---- forwarded read from port 1 ----
    do_write(A_SEL, 1);
    i_conf_dbus = 5'h04; i_read = 1'b1;
    tick();
    idle_in();
    check("fwd_rd_strobe1", o_readAIP_IP, 4'b0010);
    check("fwd_rd_not_yet", o_data_out, 32'h2);
    tick();
    check("fwd_rd_data",    o_data_out, 32'h1234_5678);
    i_dataOutAIP_IP[32 +: 32] = 32'h0;
    tick();
    check("fwd_rd_hold",    o_data_out, 32'h1234_5678);

    // ---- start on port 3, completion by interrupt ----
    do_write(A_SEL, 3);
    pulse_start();
    check("start_pulse", o_start_IP, 4'b1000);
    tick();
    check("start_single", o_start_IP, 4'b0000);
    read_chk("busy_stat", A_STAT, 32'h301);
    repeat (7) tick();
    i_int_IP[3] = 1'b1;
    tick();
    check("irq_lag", o_int_req, 1'b0);
    tick();
    check("irq_set", o_int_req, 1'b1);
    read_chk("done_stat", A_STAT, 32'h300);
    read_chk("pend3",     A_PEND, 32'h8);
    do_write(A_PEND, 32'h8);
    tick();
    check("irq_w1c", o_int_req, 1'b0);
    read_chk("pend3_clr", A_PEND, 32'h0);
    i_int_IP[3] = 1'b0;

    // ---- overrun, SELECT while busy, completion tracks latched port ----
    do_write(A_SEL, 0);
    pulse_start();
    tick();
    pulse_start();
    check("overrun_no_pulse", o_start_IP, 4'b0000);
    read_chk("overrun_stat", A_STAT, 32'h003);
    do_write(A_SEL, 7);
    read_chk("sel7_ignored", A_SEL, 32'h0);
    do_write(A_SEL, 2);
    i_int_IP[2] = 1'b1;
    tick();
    read_chk("wrong_port_int", A_STAT, 32'h203);
    i_int_IP[0] = 1'b1;
    tick();
    read_chk("latched_done", A_STAT, 32'h202);
    do_write(A_STAT, 32'h2);
    read_chk("overrun_clr", A_STAT, 32'h200);
    read_chk("pend_5", A_PEND, 32'h5);
    do_write(A_PEND, 32'h5);
    i_int_IP = '0;

    // ---- watchdog ----
    do_write(A_SEL, 1);
    pulse_start();
`ifdef AIP_DISPATCH_TIMEOUT_EN
    repeat (15) tick();
    read_chk("tmo_last_busy", A_STAT, 32'h101);
    read_chk("tmo_fired",     A_STAT, 32'h104);
    read_chk("tmo_pend",      A_PEND, 32'h2);
    do_write(A_STAT, 32'h4);
    read_chk("tmo_clr",       A_STAT, 32'h100);
`else
    repeat (40) tick();
    read_chk("no_tmo_busy",   A_STAT, 32'h101);
    i_int_IP[1] = 1'b1;
    tick();
    read_chk("no_tmo_done",   A_STAT, 32'h100);
    i_int_IP = '0;
`endif
    do_write(A_PEND, 32'h2);

    // ---- asynchronous reset mid-BUSY ----
    do_write(A_MASK, 32'h3);
    do_write(A_SEL, 2);
    pulse_start();
    tick();
    i_conf_dbus = 5'h01; i_data_in = 32'hFFFF; i_write = 1'b1;
    tick();
    idle_in();
    check("pre_rst_wr", o_writeAIP_IP, 4'b0100);
    #2;
    i_rst_a = 1'b1;
    #1;
    check("arst_dout", o_data_out, 32'h0);
    check("arst_wr",   o_writeAIP_IP, 4'b0000);
    check("arst_dat",  o_dataInAIP_IP, 128'h0);
    check("arst_cfg",  o_configAIP_IP, 20'h0);
    check("arst_misc", {o_int_req, o_start_IP, o_readAIP_IP}, 9'h0);
    @(negedge i_clk);
    i_rst_a = 1'b0;
    repeat (3) tick();
    check("post_rst_quiet", {o_int_req, o_start_IP}, 5'h0);
    read_chk("post_rst_stat", A_STAT, 32'h0);
    read_chk("post_rst_mask", A_MASK, 32'hF);
    read_chk("post_rst_sel",  A_SEL,  32'h0);

    // ---- randomized local traffic against the model ----
    apply_reset();
    m_sel = '0; m_bport = '0; m_mask = 4'hF; m_pend = '0; m_intprev = '0; cur_int = '0;
    m_busy = 0; m_ovr = 0; m_tmo = 0; m_age = 0;
    for (int c = 0; c < 500; c++) begin
      int          op;
      int          idx;
      bit          st, tmo_ev;
      logic [4:0]  a;
      logic [31:0] d, exp_rd;
      logic [3:0]  exp_start, rise, tset;
      logic        exp_irq;
      bit          nbusy;

      op = $urandom_range(0, 3);
      a  = A_STAT + 5'($urandom_range(0, 3));
      case (a)
        A_SEL:   d = $urandom_range(0, 7);
        A_STAT:  d = $urandom_range(0, 7);
        default: d = $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        cur_int[idx] = ~cur_int[idx];
      end
      st = ($urandom_range(0, 9) == 0);

      i_conf_dbus = a; i_data_in = d;
      i_read = (op == 1); i_write = (op == 2); i_start = st; i_int_IP = cur_int;

      exp_rd = '0;
      case (a)
        A_STAT:  exp_rd = {22'h0, m_sel, 5'h0, m_tmo, m_ovr, m_busy};
        A_MASK:  exp_rd = {28'h0, m_mask};
        A_PEND:  exp_rd = {28'h0, m_pend};
        default: exp_rd = {30'h0, m_sel};
      endcase
      exp_start = (st && !m_busy) ? (4'b0001 << m_sel) : 4'b0000;
      exp_irq   = |(m_pend & m_mask);

      tick();
      if (op == 1) check($sformatf("rnd_rd%0d", c), o_data_out, exp_rd);
      check($sformatf("rnd_start%0d", c), o_start_IP, exp_start);
      check($sformatf("rnd_irq%0d", c), o_int_req, exp_irq);

      rise = cur_int & ~m_intprev;
      m_intprev = cur_int;
      tset = '0; tmo_ev = 0; nbusy = m_busy;
      if (m_busy) begin
        if (rise[m_bport]) nbusy = 0;
        else begin
          m_age++;
`ifdef AIP_DISPATCH_TIMEOUT_EN
          if (m_age == TO) begin
            nbusy = 0; tmo_ev = 1; tset[m_bport] = 1'b1;
          end
`endif
        end
      end else if (st) begin
        nbusy = 1; m_bport = m_sel; m_age = 0;
      end
      if (op == 2 && a == A_STAT) begin
        if (d[1]) m_ovr = 0;
        if (d[2]) m_tmo = 0;
      end
      if (m_busy && st) m_ovr = 1;
      if (tmo_ev) m_tmo = 1;
      if (op == 2 && a == A_PEND) m_pend = m_pend & ~d[3:0];
      m_pend = m_pend | rise | tset;
      if (op == 2 && a == A_MASK) m_mask = d[3:0];
      if (op == 2 && a == A_SEL && d < 32'd4) m_sel = d[1:0];
      m_busy = nbusy;
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
